spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

Receive-side counterpart of the team's 16-bit SPI master. It over-samples the `SCLK`/`DIN` pair in the system clock domain and assembles 16-bit MSB-first frames. Each completed word is presented on `data_out` with a one-cycle `data_valid` strobe. The link has no chip-select, so frame boundaries come from the bit count plus an idle-timeout resynchronisation. Typical uses are a loopback self-test of the master and a peripheral-side register loader.

## Interface
- `DATA_W`, 16: frame length in bits. Legal range is 2..32.
- `TIMEOUT`, 16: clk cycles without an SCLK rising edge, in mid-frame, before the partial frame is dropped. Must be greater than the max SCLK period in clk cycles (4 for the team's master).
- `clk` input, 1: system clock (1 MHz nominal). Single clock domain.
- `rst` input, 1: synchronous, active-high reset.
- `SCLK` input, 1: serial clock. Idles low. Asynchronous to `clk`.
- `DIN` input, 1: serial data. Changes on SCLK falling edge and is sampled on SCLK rising edge.
- `data_out` output, DATA_W: last completed frame, MSB = first bit received. Holds its value until the next completed frame.
- `data_valid` output, 1: one-cycle pulse when `data_out` updates.
- `busy` output, 1: high while a frame is partially received (at least 1 bit in, fewer than DATA_W).
- `frame_err` output, 1: one-cycle pulse when a partial frame is dropped by timeout.

## Operation
- **Reset values:**
  - `data_out` = 0, `data_valid` = 0, `busy` = 0, `frame_err` = 0.
  - Bit counter = 0, idle counter = 0, shift register = 0.
  - Synchroniser flops = 0.
- **Synchronisation:**
  - `SCLK` and `DIN` each pass through an identical 2-flop synchroniser, so they stay mutually aligned.
  - A third flop on synced SCLK provides `sclk_prev`.
  - `rise` = `sclk_s & ~sclk_prev`. Falling edges are ignored.
- **States:**
  - IDLE: bit counter = 0, `busy` = 0.
  - SHIFT: 1 ≤ bit counter ≤ DATA_W-1, `busy` = 1.
- **On `rise`:**
  - Shift register shifts left with `din_s` entering the LSB. Bit counter increments.
  - Idle counter clears.
  - IDLE→SHIFT happens on the first `rise`.
- **Frame completion:** on the `rise` with bit counter = DATA_W-1:
  - `data_out` <= {shift[DATA_W-2:0], din_s}.
  - `data_valid` <= 1.
  - Bit counter <= 0, and the block returns to IDLE in the same edge.
- **Idle counter:**
  - In SHIFT it increments on every clk without `rise`.
  - On reaching TIMEOUT-1, the next clk does all of the following: `frame_err` <= 1, bit counter <= 0, shift register <= 0, state <= IDLE.
  - `data_out` is unchanged by a timeout.
  - The idle counter is held at 0 while in IDLE.
- **Simultaneous events:**
  - If `rise` and timeout expiry coincide, `rise` wins: the bit is accepted and no error is raised.
- **Reset mid-frame:** the partial frame is discarded with no `frame_err`. The next `rise` starts a new frame.
- **Back-to-back frames:** supported with zero gap. The first `rise` after completion starts the next frame.
- **Width rules:**
  - Bit counter is $clog2(DATA_W+1) bits wide. Idle counter is $clog2(TIMEOUT+1) bits wide.
  - Both counters saturate and never wrap.

## Timing
- **Input constraints:** SCLK high and low phases are each at least 2 clk cycles. DIN is stable for at least 2 clk cycles either side of the SCLK rising edge. The team's master meets both (2 clk high, 2 clk low).
- **Latency:**
  - Let edge n be the first clk edge that samples the final SCLK rising edge high.
  - `rise` is high in the cycle after edge n+1.
  - `data_valid` and the new `data_out` are visible after edge n+2, so latency is 3 clk edges.
- **Pulse width:** `data_valid` and `frame_err` are high for exactly 1 cycle and never high together.
- **Throughput:** one frame per DATA_W SCLK periods, i.e. 64 clk for the team's master. There is no backpressure; the consumer must capture `data_out` before the next `data_valid`.

## Structure
- **Shared package `spi_pkg`:**
  - `SPI_FRAME_W` = 16.
  - `SPI_SCLK_HALF` = 2, the clk cycles per SCLK phase.
  - `SPI_RX_TIMEOUT` = 16.
  - `spi_pkg` is shared with the master.
- **Sub-module `spi_sync_edge`:** a 2-flop synchroniser plus previous-value flop that outputs the synced level and `rise`. It is instantiated for SCLK; the DIN path uses the same synchroniser without edge output.
- **Top level:** the remainder (counters, shift register, output registers) lives in `spi_slave_rx`.

## Test plan
- **Single frame:** reset, then drive 0xA5C3 MSB-first at 4 clk per bit. Expect one `data_valid` pulse 3 clk edges after the 16th rise, `data_out` = 0xA5C3, `busy` high from the first bit until completion, and `frame_err` = 0.
- **Back-to-back frames:** send 0x0001 then 0x8000 with no gap. Expect two `data_valid` pulses 64 clk apart with `data_out` 0x0001 then 0x8000.
- **Truncated frame:** send 9 bits, idle 20 clk, then a full 0x1234. Expect a `frame_err` pulse TIMEOUT clk after the 9th rise, `data_out` still holding its prior value, then `data_out` = 0x1234 with `data_valid`.
- **Reset mid-frame:** assert `rst` for 1 cycle after bit 7, then send 0xFFFF. Expect all outputs 0 after reset, no `frame_err`, and `data_out` = 0xFFFF.
- **DIN noise while SCLK low:** toggle DIN every clk with SCLK held low, then send 0x5A5A. Expect no `data_valid` and no `busy` during the noise, then `data_out` = 0x5A5A.
- **Rise at timeout:** place the 2nd rise exactly TIMEOUT-1 cycles after the 1st. Expect no `frame_err` and the frame to complete normally.

Source files
------------

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the team's 16-bit SPI master and the
// receive-side slave. Holds the frame width, the SCLK half-period the master
// produces (in system clocks), the receive idle timeout and the receiver
// state encoding.
// ---------------------------------------------------------------------------
package spi_pkg;

   // Frame length in bits used by both master and slave.
   localparam int SPI_FRAME_W    = 16;

   // System clocks per SCLK phase generated by the master (2 high, 2 low).
   localparam int SPI_SCLK_HALF  = 2;

   // Clocks without an SCLK rising edge, mid-frame, before a partial frame
   // is dropped. Must exceed the SCLK period (2 * SPI_SCLK_HALF).
   localparam int SPI_RX_TIMEOUT = 16;

   // Receiver states: IDLE has no bits in hand, SHIFT holds a partial frame.
   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_t;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchroniser for a small bus of asynchronous inputs, plus a
// previous-value flop on bit 0 that yields a single-cycle rising-edge strobe.
// Every bit passes through the same two flops, so bits that arrive together
// stay mutually aligned after synchronisation.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset, clears all flops
//   i_d      asynchronous inputs (bit 0 is the edge-detected signal)
//   o_level  synchronised levels
//   o_rise   one-cycle strobe on a synchronised 0->1 transition of bit 0
// ---------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_level,
   output logic         o_rise
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;
   logic         r_prev;

   // Two-stage synchroniser for the whole bus, followed by a delayed copy of
   // bit 0 so a rising edge can be seen as "now high, previously low".
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
         r_prev <= r_sync[0];
      end
   end

   // Only rising edges matter to the receiver; falling edges are ignored.
   assign o_level = r_sync;
   assign o_rise  = r_sync[0] & ~r_prev;

endmodule : spi_sync_edge

// File: rtl/spi_slave_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx
// Receive side of the team's SPI link. Over-samples SCLK/DIN in the system
// clock domain and assembles DATA_W-bit MSB-first frames. There is no chip
// select: frames are delimited by the bit count, and a partial frame is
// dropped if SCLK stays quiet for TIMEOUT clocks.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   SCLK        serial clock, idles low, asynchronous to clk
//   DIN         serial data, sampled on SCLK rising edge
//   data_out    last completed frame, MSB = first bit received
//   data_valid  one-cycle strobe when data_out updates
//   busy        high while a frame is partially received
//   frame_err   one-cycle strobe when a partial frame is dropped by timeout
// ---------------------------------------------------------------------------
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_W  = SPI_FRAME_W,
   parameter int TIMEOUT = SPI_RX_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCLK,
   input  logic              DIN,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              busy,
   output logic              frame_err
);

   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  BIT_SAT   = CNT_W'(DATA_W);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(TIMEOUT);

   rx_state_t         r_state;
   rx_state_t         w_nextState;
   logic [CNT_W-1:0]  r_bitCnt;
   logic [IDLE_W-1:0] r_idleCnt;
   logic [DATA_W-1:0] r_shift;

   logic [1:0]        w_syncLevel;
   logic              w_rise;
   logic              w_din;
   logic              w_unusedSclkLevel;
   logic              w_busy;
   logic              w_complete;
   logic              w_timeout;

   // SCLK and DIN share one synchroniser so the sampled data bit lines up
   // with the SCLK edge that qualifies it. Bit 0 carries SCLK for edge
   // detection; the synced SCLK level itself is not needed downstream.
   spi_sync_edge #(
      .W (2)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_d     ({DIN, SCLK}),
      .o_level (w_syncLevel),
      .o_rise  (w_rise)
   );

   assign w_din             = w_syncLevel[1];
   assign w_unusedSclkLevel = w_syncLevel[0];

   // State register: IDLE means no bits in hand, SHIFT means a partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RX_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. The first rising edge opens a frame; the last bit or
   // an idle timeout closes it. A rise on the timeout cycle suppresses the
   // timeout, so the frame carries on.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         RX_IDLE: begin
            if (w_rise) begin
               w_nextState = RX_SHIFT;
            end
         end
         RX_SHIFT: begin
            if (w_complete || w_timeout) begin
               w_nextState = RX_IDLE;
            end
         end
         default: begin
            w_nextState = RX_IDLE;
         end
      endcase
   end

   // Output/strobe decode. Completion and timeout are qualified by SHIFT so
   // neither can fire from IDLE, and timeout is masked by a simultaneous rise.
   always_comb begin
      w_busy     = (r_state == RX_SHIFT);
      w_complete = w_rise && (r_state == RX_SHIFT) && (r_bitCnt == BIT_LAST);
      w_timeout  = !w_rise && (r_state == RX_SHIFT) && (r_idleCnt == IDLE_LAST);
   end

   // Datapath: shift register, bit and idle counters, output registers.
   // Counters saturate rather than wrap; in normal operation the bit counter
   // is cleared before reaching DATA_W and the idle counter before TIMEOUT.
   // A timeout clears the partial frame but leaves data_out alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift    <= '0;
         r_bitCnt   <= '0;
         r_idleCnt  <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= w_complete;
         frame_err  <= w_timeout;
         if (w_rise) begin
            r_shift   <= {r_shift[DATA_W-2:0], w_din};
            r_idleCnt <= '0;
            if (w_complete) begin
               r_bitCnt <= '0;
               data_out <= {r_shift[DATA_W-2:0], w_din};
            end else if (r_bitCnt != BIT_SAT) begin
               r_bitCnt <= r_bitCnt + 1'b1;
            end
         end else if (w_timeout) begin
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_idleCnt <= '0;
         end else if (r_state == RX_SHIFT) begin
            if (r_idleCnt != IDLE_SAT) begin
               r_idleCnt <= r_idleCnt + 1'b1;
            end
         end else begin
            r_idleCnt <= '0;
         end
      end
   end

   assign busy = w_busy;

endmodule : spi_slave_rx

// File: tb/tb_spi_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_rx
// Directed testbench for spi_slave_rx with DATA_W = 16, TIMEOUT = 16.
// SCLK/DIN are driven like the team's master: 2 clk low, 2 clk high per bit,
// DIN changing together with the SCLK falling edge. A monitor records
// strobes and the cycle they appear in; each scenario task compares those
// records against hand-computed values.
// ---------------------------------------------------------------------------
module tb_spi_slave_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        SCLK;
   logic        DIN;
   logic [15:0] data_out;
   logic        data_valid;
   logic        busy;
   logic        frame_err;

   int passCnt  = 0;
   int totalCnt = 0;

   int cyc = 0;
   int riseSet;

   int          validCount = 0;
   int          errCount   = 0;
   int          busyCount  = 0;
   int          bothCount  = 0;
   int          validCyc   = 0;
   int          prevValidCyc = 0;
   int          errCyc     = 0;
   logic [15:0] lastData   = '0;
   logic [15:0] prevData   = '0;
   logic [15:0] errData    = '0;

   spi_slave_rx #(
      .DATA_W  (16),
      .TIMEOUT (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .SCLK       (SCLK),
      .DIN        (DIN),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .frame_err  (frame_err)
   );

   // 100 MHz simulation clock; only relative cycle counts matter.
   always #5 clk = ~clk;

   // Free-running cycle number, advanced on every rising clock edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor samples 1 ns after each rising edge and records strobe events,
   // the cycle they landed in and the data visible at that moment.
   always @(posedge clk) begin
      #1;
      if (data_valid) begin
         prevData     = lastData;
         prevValidCyc = validCyc;
         lastData     = data_out;
         validCyc     = cyc;
         validCount++;
      end
      if (frame_err) begin
         errCount++;
         errCyc  = cyc;
         errData = data_out;
      end
      if (busy) busyCount++;
      if (data_valid && frame_err) bothCount++;
   end

   // Safety net so a stuck run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passCnt, totalCnt);
      $fatal(1, "[TB] watchdog expired");
   end

   // One bit as the master sends it: SCLK low for 2 clk with DIN presented,
   // then SCLK high for 2 clk. riseSet records the cycle SCLK went high.
   task automatic send_bit(input logic b);
      @(negedge clk);
      SCLK = 1'b0;
      DIN  = b;
      @(negedge clk);
      @(negedge clk);
      SCLK    = 1'b1;
      riseSet = cyc;
      @(negedge clk);
   endtask

   // Sends the low n bits of val, MSB first.
   task automatic send_bits(input logic [31:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         send_bit(val[i]);
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      SCLK = 1'b0;
      DIN  = 1'b0;
      repeat (3) @(negedge clk);
      totalCnt++; if (data_out !== 16'h0000) $display("[TB] FAIL reset_data_out: got %h want 0000", data_out); else passCnt++;
      totalCnt++; if (data_valid !== 1'b0) $display("[TB] FAIL reset_data_valid: got %b want 0", data_valid); else passCnt++;
      totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCnt++;
      totalCnt++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err: got %b want 0", frame_err); else passCnt++;
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // 0xA5C3; the first bit's SCLK high phase is stretched by 2 clk so busy
   // can be checked mid-frame. busy is high from the cycle after the first
   // rise is taken until the completion edge, i.e. r16 - r1 cycles.
   task automatic test_single_frame();
      int vc0, ec0, bc0, r1;
      vc0 = validCount; ec0 = errCount; bc0 = busyCount;
      send_bit(1'b1);
      r1 = riseSet;
      repeat (2) @(negedge clk);
      totalCnt++; if (busy !== 1'b1) $display("[TB] FAIL single_busy_mid: got %b want 1", busy); else passCnt++;
      send_bits(32'h0000_25C3, 15);
      repeat (6) @(negedge clk);
      totalCnt++; if (validCount - vc0 !== 1) $display("[TB] FAIL single_valid_count: got %0d want 1", validCount - vc0); else passCnt++;
      totalCnt++; if (lastData !== 16'hA5C3) $display("[TB] FAIL single_data: got %h want a5c3", lastData); else passCnt++;
      totalCnt++; if (validCyc - riseSet !== 3) $display("[TB] FAIL single_latency: got %0d want 3", validCyc - riseSet); else passCnt++;
      totalCnt++; if (data_out !== 16'hA5C3) $display("[TB] FAIL single_hold: got %h want a5c3", data_out); else passCnt++;
      totalCnt++; if (errCount - ec0 !== 0) $display("[TB] FAIL single_no_err: got %0d want 0", errCount - ec0); else passCnt++;
      totalCnt++; if (busyCount - bc0 !== riseSet - r1) $display("[TB] FAIL single_busy_cycles: got %0d want %0d", busyCount - bc0, riseSet - r1); else passCnt++;
      totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_end: got %b want 0", busy); else passCnt++;
   endtask

   task automatic test_back_to_back();
      int vc0;
      vc0 = validCount;
      send_bits(32'h0000_0001, 16);
      send_bits(32'h0000_8000, 16);
      repeat (6) @(negedge clk);
      totalCnt++; if (validCount - vc0 !== 2) $display("[TB] FAIL b2b_valid_count: got %0d want 2", validCount - vc0); else passCnt++;
      totalCnt++; if (prevData !== 16'h0001) $display("[TB] FAIL b2b_first_data: got %h want 0001", prevData); else passCnt++;
      totalCnt++; if (lastData !== 16'h8000) $display("[TB] FAIL b2b_second_data: got %h want 8000", lastData); else passCnt++;
      totalCnt++; if (validCyc - prevValidCyc !== 64) $display("[TB] FAIL b2b_spacing: got %0d want 64", validCyc - prevValidCyc); else passCnt++;
   endtask

   // 9 bits then silence. The 9th rise is taken 3 clk after SCLK goes high,
   // and the error strobe follows TIMEOUT = 16 clk later: 19 in total.
   task automatic test_truncated();
      int vc0, ec0, r9;
      vc0 = validCount; ec0 = errCount;
      send_bits(32'h0000_016D, 9);
      r9 = riseSet;
      @(negedge clk);
      SCLK = 1'b0;
      repeat (19) @(negedge clk);
      totalCnt++; if (errCount - ec0 !== 1) $display("[TB] FAIL trunc_err_count: got %0d want 1", errCount - ec0); else passCnt++;
      totalCnt++; if (errCyc - r9 !== 19) $display("[TB] FAIL trunc_err_time: got %0d want 19", errCyc - r9); else passCnt++;
      totalCnt++; if (errData !== 16'h8000) $display("[TB] FAIL trunc_data_held: got %h want 8000", errData); else passCnt++;
      totalCnt++; if (validCount - vc0 !== 0) $display("[TB] FAIL trunc_no_valid: got %0d want 0", validCount - vc0); else passCnt++;
      totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL trunc_busy: got %b want 0", busy); else passCnt++;
      send_bits(32'h0000_1234, 16);
      repeat (6) @(negedge clk);
      totalCnt++; if (validCount - vc0 !== 1) $display("[TB] FAIL trunc_next_valid: got %0d want 1", validCount - vc0); else passCnt++;
      totalCnt++; if (lastData !== 16'h1234) $display("[TB] FAIL trunc_next_data: got %h want 1234", lastData); else passCnt++;
      totalCnt++; if (errCount - ec0 !== 1) $display("[TB] FAIL trunc_no_extra_err: got %0d want 1", errCount - ec0); else passCnt++;
   endtask

   task automatic test_reset_mid_frame();
      int ec0, vc0;
      ec0 = errCount;
      send_bits(32'h0000_0055, 7);
      @(negedge clk);
      SCLK = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      totalCnt++; if (data_out !== 16'h0000) $display("[TB] FAIL rstmid_data_out: got %h want 0000", data_out); else passCnt++;
      totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b want 0", busy); else passCnt++;
      totalCnt++; if (data_valid !== 1'b0 || frame_err !== 1'b0) $display("[TB] FAIL rstmid_strobes: got valid=%b err=%b want 0 0", data_valid, frame_err); else passCnt++;
      repeat (25) @(negedge clk);
      totalCnt++; if (errCount - ec0 !== 0) $display("[TB] FAIL rstmid_no_err: got %0d want 0", errCount - ec0); else passCnt++;
      vc0 = validCount;
      send_bits(32'h0000_FFFF, 16);
      repeat (6) @(negedge clk);
      totalCnt++; if (validCount - vc0 !== 1) $display("[TB] FAIL rstmid_valid: got %0d want 1", validCount - vc0); else passCnt++;
      totalCnt++; if (data_out !== 16'hFFFF) $display("[TB] FAIL rstmid_data: got %h want ffff", data_out); else passCnt++;
   endtask

   task automatic test_din_noise();
      int vc0, bc0;
      vc0 = validCount; bc0 = busyCount;
      SCLK = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         DIN = ~DIN;
      end
      repeat (4) @(negedge clk);
      totalCnt++; if (validCount - vc0 !== 0) $display("[TB] FAIL noise_no_valid: got %0d want 0", validCount - vc0); else passCnt++;
      totalCnt++; if (busyCount - bc0 !== 0) $display("[TB] FAIL noise_no_busy: got %0d want 0", busyCount - bc0); else passCnt++;
      send_bits(32'h0000_5A5A, 16);
      repeat (6) @(negedge clk);
      totalCnt++; if (validCount - vc0 !== 1) $display("[TB] FAIL noise_valid: got %0d want 1", validCount - vc0); else passCnt++;
      totalCnt++; if (lastData !== 16'h5A5A) $display("[TB] FAIL noise_data: got %h want 5a5a", lastData); else passCnt++;
   endtask

   // The 2nd SCLK rise is driven 16 clk after the 1st, so it is taken on
   // the very edge where the idle counter sits at TIMEOUT-1 and would
   // otherwise expire. The rise must win: no error, frame completes.
   task automatic test_rise_at_timeout();
      int vc0, ec0, r1;
      logic [15:0] word;
      word = 16'hBEEF;
      vc0 = validCount; ec0 = errCount;
      send_bit(word[15]);
      r1 = riseSet;
      @(negedge clk);
      SCLK = 1'b0;
      DIN  = word[14];
      while (cyc < r1 + 16) @(negedge clk);
      SCLK    = 1'b1;
      riseSet = cyc;
      @(negedge clk);
      send_bits({16'h0000, word}, 14);
      repeat (6) @(negedge clk);
      totalCnt++; if (errCount - ec0 !== 0) $display("[TB] FAIL rto_no_err: got %0d want 0", errCount - ec0); else passCnt++;
      totalCnt++; if (validCount - vc0 !== 1) $display("[TB] FAIL rto_valid: got %0d want 1", validCount - vc0); else passCnt++;
      totalCnt++; if (lastData !== 16'hBEEF) $display("[TB] FAIL rto_data: got %h want beef", lastData); else passCnt++;
      totalCnt++; if (bothCount !== 0) $display("[TB] FAIL strobes_overlap: got %0d want 0", bothCount); else passCnt++;
   endtask

   // Scenario sequence.
   initial begin
      $display("[TB] spi_slave_rx directed test start");
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_truncated();
      test_reset_mid_frame();
      test_din_noise();
      test_rise_at_timeout();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule : tb_spi_slave_rx
